// File: rtl/seg_scanner.sv
// Four-digit multiplexed seven-segment scanner: steps one digit per rising edge
// of the slow scan clock and shows a per-frame snapshot of the value.
module seg_scanner #(
  parameter bit BLANK_LEADING = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        div_clock,
  input  logic [15:0] value,
  input  logic [3:0]  dp_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h40;
      4'h1:    pat = 7'h79;
      4'h2:    pat = 7'h24;
      4'h3:    pat = 7'h30;
      4'h4:    pat = 7'h19;
      4'h5:    pat = 7'h12;
      4'h6:    pat = 7'h02;
      4'h7:    pat = 7'h78;
      4'h8:    pat = 7'h00;
      4'h9:    pat = 7'h10;
      4'hA:    pat = 7'h08;
      4'hB:    pat = 7'h03;
      4'hC:    pat = 7'h46;
      4'hD:    pat = 7'h21;
      4'hE:    pat = 7'h06;
      4'hF:    pat = 7'h0E;
      default: pat = 7'h7F;
    endcase
    return pat;
  endfunction

  // True when digit k (k>0) and every digit above it is zero; digit 0 always shows.
  function automatic logic is_leading_zero(input logic [15:0] s, input logic [1:0] k);
    logic blank;
    case (k)
      2'd1:    blank = (s[15:4]  == 12'h000);
      2'd2:    blank = (s[15:8]  == 8'h00);
      2'd3:    blank = (s[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
    return blank;
  endfunction

  logic        div_q;
  logic        tick_s;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] snap_q, snap_d;
  logic        fd_q, fd_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [3:0]  nib_s;

  always_comb begin
    tick_s = div_clock & ~div_q;
    idx_d  = idx_q;
    snap_d = snap_q;
    fd_d   = 1'b0;
    if (tick_s) begin
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        snap_d = value;
        fd_d   = 1'b1;
      end else begin
        snap_d = snap_q;
      end
    end else begin
      idx_d = idx_q;
    end

    // Display path looks at the current idx/snap, so it trails them by one cycle.
    nib_s = snap_q[{idx_q, 2'b00} +: 4];
    an_d  = ~(4'b0001 << idx_q);
    if (BLANK_LEADING && is_leading_zero(snap_q, idx_q)) begin
      seg_d = 7'h7F;
    end else begin
      seg_d = hex_to_seg(nib_s);
    end
    dp_d = ~dp_en[idx_q];
  end

  // Loading div_q from div_clock during reset prevents a false tick on release.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_q  <= div_clock;
      idx_q  <= 2'd0;
      snap_q <= 16'h0000;
      fd_q   <= 1'b0;
      an_q   <= 4'b1111;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
    end else begin
      div_q  <= div_clock;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      fd_q   <= fd_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scanner.sv
// Bench for seg_scanner: both blanking variants driven in parallel and checked
// every cycle against a digit-position model, plus hand-computed spot checks.
module tb_seg_scanner;

  logic        clock = 1'b0;
  logic        reset;
  logic        div_clock;
  logic [15:0] value;
  logic [3:0]  dp_en;
  logic [3:0]  an0, an1;
  logic [6:0]  seg0, seg1;
  logic        dp0, dp1, fd0, fd1;

  int n_cmp  = 0;
  int n_fail = 0;

  seg_scanner #(.BLANK_LEADING(1'b0)) u_dut0 (
    .clock(clock), .reset(reset), .div_clock(div_clock), .value(value), .dp_en(dp_en),
    .an(an0), .seg(seg0), .dp(dp0), .frame_done(fd0));

  seg_scanner #(.BLANK_LEADING(1'b1)) u_dut1 (
    .clock(clock), .reset(reset), .div_clock(div_clock), .value(value), .dp_en(dp_en),
    .an(an1), .seg(seg1), .dp(dp1), .frame_done(fd1));

  always #5 clock = ~clock;

  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state: which digit position is lit and which frame value it is showing.
  int          pos = 0;
  logic [15:0] shown = 16'h0;
  logic        prev_div = 1'b0;
  logic        valid = 1'b0;
  logic [3:0]  e_an;
  logic [6:0]  e_seg0, e_seg1;
  logic        e_dp, e_fd;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic d, input logic [15:0] v, input logic [3:0] dpe);
    int digit;
    int upper;
    if (r) begin
      e_an = 4'hF; e_seg0 = 7'h7F; e_seg1 = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
      pos = 0; shown = 16'h0; valid = 1'b1;
    end else begin
      upper  = int'(shown) >> (4 * pos);
      digit  = upper % 16;
      e_an   = 4'hF;
      e_an[pos] = 1'b0;
      e_seg0 = tbl[digit];
      e_seg1 = (pos > 0 && upper == 0) ? 7'h7F : tbl[digit];
      e_dp   = !dpe[pos];
      e_fd   = 1'b0;
      if (d && !prev_div) begin
        if (pos == 3) begin
          pos = 0; shown = v; e_fd = 1'b1;
        end else begin
          pos = pos + 1;
        end
      end
    end
    prev_div = d;
  endtask

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(posedge clock);
      model_step(reset, div_clock, value, dp_en);
      @(negedge clock);
      if (valid) begin
        check("an_b0",  {12'h0, an0},  {12'h0, e_an});
        check("an_b1",  {12'h0, an1},  {12'h0, e_an});
        check("seg_b0", {9'h0, seg0},  {9'h0, e_seg0});
        check("seg_b1", {9'h0, seg1},  {9'h0, e_seg1});
        check("dp",     {14'h0, dp1, dp0}, {14'h0, e_dp, e_dp});
        check("fd",     {14'h0, fd1, fd0}, {14'h0, e_fd, e_fd});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse();
    div_clock = 1'b1; cyc(2);
    div_clock = 1'b0; cyc(2);
  endtask

  initial begin
    reset = 1'b1; div_clock = 1'b1; value = 16'h0; dp_en = 4'b0000;
    cyc(3);
    check("rst_an",  {12'h0, an0}, 16'h000F);
    check("rst_seg", {9'h0, seg0}, 16'h007F);
    check("rst_dp",  {15'h0, dp0}, 16'h0001);
    check("rst_fd",  {15'h0, fd0}, 16'h0000);

    // Release with div_clock already high: no tick, digit 0 shows zero.
    reset = 1'b0;
    cyc(1);
    check("rel_an",  {12'h0, an0}, 16'h000E);
    check("rel_seg", {9'h0, seg0}, 16'h0040);
    cyc(20);
    check("hold_an",  {12'h0, an0}, 16'h000E);
    check("hold_seg", {9'h0, seg0}, 16'h0040);
    div_clock = 1'b0; cyc(2);

    // First frame loads 1234 on the wrap tick.
    value = 16'h1234;
    pulse(); pulse(); pulse();
    div_clock = 1'b1; cyc(1);
    check("wrap_fd", {15'h0, fd0}, 16'h0001);
    cyc(1);
    check("fd_once", {15'h0, fd0}, 16'h0000);
    check("d0_an",   {12'h0, an0}, 16'h000E);
    check("d0_seg",  {9'h0, seg0}, 16'h0019);
    div_clock = 1'b0; cyc(2);
    pulse();
    check("d1_an",  {12'h0, an0}, 16'h000D);
    check("d1_seg", {9'h0, seg0}, 16'h0030);

    // Mid-frame value change must wait for the next wrap.
    value = 16'hABCD;
    pulse();
    check("d2_seg", {9'h0, seg0}, 16'h0024);
    pulse();
    check("d3_an",  {12'h0, an0}, 16'h0007);
    check("d3_seg", {9'h0, seg0}, 16'h0079);
    pulse();
    check("n0_seg", {9'h0, seg0}, 16'h0021);
    pulse();
    check("n1_seg", {9'h0, seg0}, 16'h0046);

    // Decimal point on digit 2 only, then cleared mid-digit.
    dp_en = 4'b0100;
    cyc(1);
    check("dp_d1", {15'h0, dp0}, 16'h0001);
    pulse();
    check("dp_an", {12'h0, an0}, 16'h000B);
    check("dp_on", {15'h0, dp0}, 16'h0000);
    dp_en = 4'b0000;
    cyc(1);
    check("dp_off", {15'h0, dp0}, 16'h0001);

    // Leading-zero blanking with 0050 then 0000.
    value = 16'h0050;
    pulse(); pulse();
    check("bl0_seg", {9'h0, seg1}, 16'h0040);
    pulse();
    check("bl1_seg", {9'h0, seg1}, 16'h0012);
    pulse();
    check("bl2_seg", {9'h0, seg1}, 16'h007F);
    check("nb2_seg", {9'h0, seg0}, 16'h0040);
    check("bl2_an",  {12'h0, an1}, 16'h000B);
    value = 16'h0000;
    pulse(); pulse();
    check("z0_seg", {9'h0, seg1}, 16'h0040);
    pulse();
    check("z1_seg", {9'h0, seg1}, 16'h007F);

    // Back-to-back scan edges, period two clocks.
    for (int i = 0; i < 24; i++) begin
      value = 16'($urandom);
      dp_en = 4'($urandom);
      div_clock = ~div_clock;
      cyc(1);
    end
    div_clock = 1'b0; cyc(2);

    // Reset colliding with a tick at idx 2.
    value = 16'h5678;
    while (an0 != 4'b1101) pulse();
    pulse();
    div_clock = 1'b1; reset = 1'b1;
    cyc(1);
    check("rc_an", {12'h0, an0}, 16'h000F);
    check("rc_fd", {15'h0, fd0}, 16'h0000);
    reset = 1'b0;
    cyc(1);
    check("rc_rel_an", {12'h0, an0}, 16'h000E);
    cyc(3);
    check("rc_fd2", {15'h0, fd0}, 16'h0000);

    // Random stretch: mixed edge spacing, values and decimal points.
    for (int i = 0; i < 300; i++) begin
      div_clock = 1'($urandom_range(0, 1));
      value     = 16'($urandom);
      dp_en     = 4'($urandom);
      reset     = ($urandom_range(0, 99) == 0);
      cyc(1);
    end
    reset = 1'b0;
    cyc(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scanner.md
SEG_SCANNER -- requirements
Module: seg_scanner

Interface
REQ-001 Parameter BLANK_LEADING, default 0: 1 SHALL blank leading-zero digits, 0 SHALL show all four digits.
REQ-002 clock  in  1  system clock; single clock domain; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 div_clock  in  1  slow square-wave scan clock from the upstream divider, synchronous to clock; used only as data, never as a clock.
REQ-005 value  in  16  four hex nibbles to display; digit k = value[4k+3:4k], digit 0 rightmost.
REQ-006 dp_en  in  4  decimal-point enable per digit, bit k = digit k.
REQ-007 an  out  4  digit anodes, active-low, one-hot-low when active.
REQ-008 seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-009 dp  out  1  decimal point, active-low.
REQ-010 frame_done  out  1  one-cycle pulse per completed four-digit scan.

Function
REQ-011 div_q SHALL register div_clock every cycle; tick SHALL equal div_clock AND NOT div_q (one pulse per div_clock rising edge).
REQ-012 On tick, the 2-bit digit index idx SHALL increment, wrapping 3 -> 0.
REQ-013 On the tick where idx wraps 3 -> 0, snap SHALL load value and frame_done SHALL be 1 for the next cycle only; otherwise frame_done SHALL be 0.
REQ-014 Between frames, changes on value SHALL NOT affect displayed digits; dp_en SHALL be sampled live.
REQ-015 an, seg and dp SHALL be registered from idx, snap and dp_en with exactly one cycle latency after idx/snap update.
REQ-016 an SHALL be ~(4'b0001 << idx).
REQ-017 seg SHALL decode nibble snap[4*idx+3:4*idx] as hex 0..F -> 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex).
REQ-018 dp SHALL be ~dp_en[idx].
REQ-019 With BLANK_LEADING=1, digit k>0 SHALL show seg=7F when all nibbles of snap at positions >= k are zero; digit 0 SHALL never be blanked; an and dp SHALL be unaffected.
REQ-020 div_clock held constant (high or low) SHALL produce no further ticks; idx and outputs SHALL hold.
REQ-021 Back-to-back div_clock edges (period 2 clocks) SHALL each advance idx exactly once.

Reset
REQ-022 While reset=1: div_q <= div_clock (no spurious tick on release), idx=0, snap=0, frame_done=0, an=4'b1111, seg=7F, dp=1.
REQ-023 Reset SHALL take priority over tick and over frame snapshot in the same cycle.
REQ-024 First cycle after reset release: an=4'b1110, seg=40, dp=~dp_en[0].
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no frame_done pulse.

Verification
REQ-026 Reset with div_clock=1, release, hold div_clock=1 -> no tick; an stays 1110, seg=40 indefinitely.
REQ-027 value=16'h1234, four div_clock rising edges -> after 4th, frame_done one pulse; next frame shows an 1110/1101/1011/0111 with seg 19,30,24,79.
REQ-028 value changed 1234 -> ABCD mid-frame -> digits keep showing 1234 until wrap, then 0D-frame shows 21,46,03,08.
REQ-029 BLANK_LEADING=1, value=16'h0050 -> digit0 seg=40, digit1 seg=12, digits 2,3 seg=7F; value=0 -> only digit0 shows 40.
REQ-030 dp_en=4'b0100 -> dp=0 only while an=1011; dp_en toggled mid-frame takes effect one cycle later.
REQ-031 reset pulsed while idx=2 and tick coincident -> idx=0, an=1111 in reset cycle, no frame_done, then an=1110.
